// File: rtl/jump_ctrl.sv
// Front-end redirect controller: arbitrates EX branch correction against ID static
// predictions, drives PC redirect/flush/stall, and counts resolved/mispredicted branches.
module jump_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prd_jump_en_i,
  input  logic [ADDR_W-1:0] prd_jump_base_i,
  input  logic [ADDR_W-1:0] prd_jump_ofset_i,
  input  logic              id_valid_i,
  input  logic              id_is_jalr_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic              ex_load_i,
  input  logic [4:0]        ex_wr_addr_i,
  input  logic              ex_br_valid_i,
  input  logic              ex_br_taken_i,
  input  logic              ex_prd_taken_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              if_ready_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    JALR_WAIT = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              hold_ex_q, hold_ex_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;

  logic              ex_mispredict;
  logic              jalr_hazard;
  logic              id_jump;
  logic [ADDR_W-1:0] ex_corr_addr;
  logic [ADDR_W-1:0] id_addr;

  logic              rdr_valid;
  logic [ADDR_W-1:0] rdr_addr;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              stall_if;
  logic              stall_id;

  always_comb begin
    ex_mispredict = ex_br_valid_i & (ex_br_taken_i ^ ex_prd_taken_i);
    ex_corr_addr  = ex_br_taken_i ? ex_target_i : (ex_pc_i + ADDR_W'(4));
    id_addr       = prd_jump_base_i + prd_jump_ofset_i;
    if (id_is_jalr_i) begin
      id_addr[0] = 1'b0;
    end
    jalr_hazard   = id_valid_i & id_is_jalr_i & prd_jump_en_i & ex_load_i &
                    (ex_wr_addr_i == id_rs1_addr_i) & (id_rs1_addr_i != 5'd0);
    id_jump       = id_valid_i & prd_jump_en_i;
  end

  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_ex_d   = hold_ex_q;
    rdr_valid   = 1'b0;
    rdr_addr    = '0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;

    unique case (state_q)
      IDLE, JALR_WAIT: begin
        state_d = IDLE;
        // JALR_WAIT skips the hazard check: the load result is forwardable by now.
        if (ex_mispredict) begin
          rdr_valid   = 1'b1;
          rdr_addr    = ex_corr_addr;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if ((state_q == IDLE) && jalr_hazard) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = JALR_WAIT;
        end else if (id_jump) begin
          rdr_valid   = 1'b1;
          rdr_addr    = id_addr;
          flush_if_id = 1'b1;
        end
        if (rdr_valid && !if_ready_i) begin
          stall_if    = 1'b1;
          state_d     = HOLD;
          hold_addr_d = rdr_addr;
          hold_ex_d   = ex_mispredict;
        end
      end
      HOLD: begin
        rdr_valid = 1'b1;
        rdr_addr  = hold_addr_q;
        // A late EX correction supersedes whatever is being held.
        if (ex_mispredict) begin
          rdr_addr    = ex_corr_addr;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          hold_addr_d = ex_corr_addr;
          hold_ex_d   = 1'b1;
        end
        if (if_ready_i) begin
          state_d = IDLE;
        end else begin
          stall_if = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (ex_br_valid_i && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (ex_mispredict && !(&mispredict_cnt_q)) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      hold_addr_q      <= '0;
      hold_ex_q        <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      hold_addr_q      <= hold_addr_d;
      hold_ex_q        <= hold_ex_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Outputs are combinational, so reset must mask them while it is asserted.
  always_comb begin
    redirect_valid_o = rdr_valid & ~rst;
    redirect_addr_o  = rst ? '0 : rdr_addr;
    flush_if_id_o    = flush_if_id & ~rst;
    flush_id_ex_o    = flush_id_ex & ~rst;
    stall_if_o       = stall_if & ~rst;
    stall_id_o       = stall_id & ~rst;
    branch_cnt_o     = branch_cnt_q;
    mispredict_cnt_o = mispredict_cnt_q;
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios plus random traffic, all scored against a
// cycle-level reference model through an expectation queue drained by a monitor.
module tb_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        prd_jump_en, id_valid, id_is_jalr, ex_load;
  logic        ex_br_valid, ex_br_taken, ex_prd_taken, if_ready;
  logic [31:0] prd_base, prd_ofs, ex_target, ex_pc;
  logic [4:0]  id_rs1, ex_wr;

  logic        rv, fi, fe, si, sd;
  logic [31:0] ra;
  logic [15:0] bc, mc;
  logic        rv4, fi4, fe4, si4, sd4;
  logic [31:0] ra4;
  logic [3:0]  bc4, mc4;

  always #5 clk = ~clk;

  jump_ctrl #(.ADDR_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .prd_jump_en_i(prd_jump_en), .prd_jump_base_i(prd_base), .prd_jump_ofset_i(prd_ofs),
    .id_valid_i(id_valid), .id_is_jalr_i(id_is_jalr), .id_rs1_addr_i(id_rs1),
    .ex_load_i(ex_load), .ex_wr_addr_i(ex_wr),
    .ex_br_valid_i(ex_br_valid), .ex_br_taken_i(ex_br_taken), .ex_prd_taken_i(ex_prd_taken),
    .ex_target_i(ex_target), .ex_pc_i(ex_pc), .if_ready_i(if_ready),
    .redirect_valid_o(rv), .redirect_addr_o(ra),
    .flush_if_id_o(fi), .flush_id_ex_o(fe), .stall_if_o(si), .stall_id_o(sd),
    .branch_cnt_o(bc), .mispredict_cnt_o(mc)
  );

  jump_ctrl #(.ADDR_W(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .prd_jump_en_i(prd_jump_en), .prd_jump_base_i(prd_base), .prd_jump_ofset_i(prd_ofs),
    .id_valid_i(id_valid), .id_is_jalr_i(id_is_jalr), .id_rs1_addr_i(id_rs1),
    .ex_load_i(ex_load), .ex_wr_addr_i(ex_wr),
    .ex_br_valid_i(ex_br_valid), .ex_br_taken_i(ex_br_taken), .ex_prd_taken_i(ex_prd_taken),
    .ex_target_i(ex_target), .ex_pc_i(ex_pc), .if_ready_i(if_ready),
    .redirect_valid_o(rv4), .redirect_addr_o(ra4),
    .flush_if_id_o(fi4), .flush_id_ex_o(fe4), .stall_if_o(si4), .stall_id_o(sd4),
    .branch_cnt_o(bc4), .mispredict_cnt_o(mc4)
  );

  typedef struct {
    logic        rv, fi, fe, si, sd;
    logic [31:0] ra;
    logic [15:0] bc, mc;
    logic [3:0]  bc4, mc4;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: a pending redirect, a one-shot "bubble already inserted" flag,
  // and unbounded event counts that are clipped to the counter width on compare.
  bit          m_pend;
  bit          m_bubble;
  logic [31:0] m_paddr;
  longint      m_nbr, m_nmis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic predict();
    exp_t        e;
    bit          mis, haz, jmp;
    logic [31:0] cor, tgt;
    e.rv = 0; e.ra = 0; e.fi = 0; e.fe = 0; e.si = 0; e.sd = 0;
    if (rst) begin
      m_pend = 0; m_bubble = 0; m_nbr = 0; m_nmis = 0;
    end
    e.bc  = 16'(sat(m_nbr, 16));
    e.mc  = 16'(sat(m_nmis, 16));
    e.bc4 = 4'(sat(m_nbr, 4));
    e.mc4 = 4'(sat(m_nmis, 4));
    if (!rst) begin
      mis = ex_br_valid && (ex_br_taken != ex_prd_taken);
      cor = ex_br_taken ? ex_target : ex_pc + 32'd4;
      tgt = prd_base + prd_ofs;
      if (id_is_jalr) tgt = tgt & 32'hFFFF_FFFE;
      haz = !mis && !m_pend && !m_bubble && id_valid && id_is_jalr && prd_jump_en &&
            ex_load && (ex_wr == id_rs1) && (id_rs1 != 5'd0);
      jmp = id_valid && prd_jump_en;
      if (mis) begin
        e.rv = 1; e.ra = cor; e.fi = 1; e.fe = 1;
      end else if (m_pend) begin
        e.rv = 1; e.ra = m_paddr;
      end else if (haz) begin
        e.si = 1; e.sd = 1; e.fe = 1;
      end else if (jmp) begin
        e.rv = 1; e.ra = tgt; e.fi = 1;
      end
      if (e.rv && !if_ready) e.si = 1;
      m_pend   = e.rv && !if_ready;
      m_paddr  = e.ra;
      m_bubble = haz;
      if (ex_br_valid) m_nbr++;
      if (mis) m_nmis++;
    end
    sbq.push_back(e);
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    prd_jump_en = 0; id_valid = 0; id_is_jalr = 0; ex_load = 0;
    ex_br_valid = 0; ex_br_taken = 0; ex_prd_taken = 0; if_ready = 1;
    prd_base = 0; prd_ofs = 0; ex_target = 0; ex_pc = 0; id_rs1 = 0; ex_wr = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("redirect_valid", {31'd0, rv}, {31'd0, e.rv});
        chk("redirect_addr", ra, e.ra);
        chk("flush_if_id", {31'd0, fi}, {31'd0, e.fi});
        chk("flush_id_ex", {31'd0, fe}, {31'd0, e.fe});
        chk("stall_if", {31'd0, si}, {31'd0, e.si});
        chk("stall_id", {31'd0, sd}, {31'd0, e.sd});
        chk("branch_cnt", {16'd0, bc}, {16'd0, e.bc});
        chk("mispredict_cnt", {16'd0, mc}, {16'd0, e.mc});
        chk("branch_cnt_w4", {28'd0, bc4}, {28'd0, e.bc4});
        chk("mispredict_cnt_w4", {28'd0, mc4}, {28'd0, e.mc4});
        chk("redirect_addr_w4", ra4, e.ra);
      end
    end
  end

  initial begin : stimulus
    bit t;
    clear_inputs();
    rst = 1;
    m_pend = 0; m_bubble = 0; m_paddr = 0; m_nbr = 0; m_nmis = 0;
    @(posedge clk); #1;
    chk("reset_redirect_valid", {31'd0, rv}, 32'd0);
    chk("reset_branch_cnt", {16'd0, bc}, 32'd0);
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Backward branch predicted taken
    clear_inputs();
    id_valid = 1; prd_jump_en = 1; prd_base = 32'h100; prd_ofs = 32'hFFFF_FFF0;
    #2;
    chk("btfn_valid", {31'd0, rv}, 32'd1);
    chk("btfn_addr", ra, 32'h0000_00F0);
    chk("btfn_flush_id_ex", {31'd0, fe}, 32'd0);
    cycle();

    // EX mispredict beats a simultaneous ID jump
    clear_inputs();
    ex_br_valid = 1; ex_br_taken = 0; ex_prd_taken = 1; ex_pc = 32'h200; ex_target = 32'h999;
    id_valid = 1; prd_jump_en = 1; prd_base = 32'h400;
    #2;
    chk("mis_addr", ra, 32'h204);
    chk("mis_flush_id_ex", {31'd0, fe}, 32'd1);
    cycle();
    clear_inputs();
    #2;
    chk("mis_cnt_after", {16'd0, mc}, 32'd1);
    chk("br_cnt_after", {16'd0, bc}, 32'd1);
    cycle();

    // JALR load-use hazard
    clear_inputs();
    id_valid = 1; prd_jump_en = 1; id_is_jalr = 1; id_rs1 = 5'd5;
    ex_load = 1; ex_wr = 5'd5; prd_base = 32'h1000; prd_ofs = 32'h3;
    #2;
    chk("jalr_stall_id", {31'd0, sd}, 32'd1);
    chk("jalr_hazard_no_redirect", {31'd0, rv}, 32'd0);
    cycle();
    ex_load = 0;
    #2;
    chk("jalr_addr", ra, 32'h1002);
    cycle();

    // Held redirect, overwritten by an EX mispredict, then released
    clear_inputs();
    id_valid = 1; prd_jump_en = 1; prd_base = 32'h80; if_ready = 0;
    cycle();
    #2;
    chk("hold_addr", ra, 32'h80);
    chk("hold_stall_if", {31'd0, si}, 32'd1);
    chk("hold_no_flush", {31'd0, fi}, 32'd0);
    cycle();
    clear_inputs();
    if_ready = 0; ex_br_valid = 1; ex_br_taken = 1; ex_prd_taken = 0; ex_target = 32'h300;
    #2;
    chk("hold_ex_overwrite", ra, 32'h300);
    cycle();
    clear_inputs();
    #2;
    chk("hold_release_addr", ra, 32'h300);
    chk("hold_release_stall", {31'd0, si}, 32'd0);
    cycle();
    #2;
    chk("post_release_idle", {31'd0, rv}, 32'd0);
    cycle();

    // Reset while holding
    clear_inputs();
    id_valid = 1; prd_jump_en = 1; prd_base = 32'h500; if_ready = 0;
    cycle();
    cycle();
    rst = 1;
    #1;
    chk("rst_hold_valid", {31'd0, rv}, 32'd0);
    chk("rst_hold_stall", {31'd0, si}, 32'd0);
    cycle();
    rst = 0;
    clear_inputs();
    #2;
    chk("rst_hold_after", {31'd0, rv}, 32'd0);
    cycle();

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      clear_inputs();
      t = 1'($urandom_range(0, 1));
      ex_br_valid = 1; ex_br_taken = t; ex_prd_taken = ~t;
      ex_target = $urandom; ex_pc = $urandom;
      cycle();
    end
    clear_inputs();
    #2;
    chk("sat_branch_cnt4", {28'd0, bc4}, 32'hF);
    chk("sat_mis_cnt4", {28'd0, mc4}, 32'hF);
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      prd_jump_en  = 1'($urandom_range(0, 1));
      id_is_jalr   = ($urandom_range(0, 3) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      ex_load      = 1'($urandom_range(0, 1));
      ex_wr        = 5'($urandom_range(0, 3));
      ex_br_valid  = ($urandom_range(0, 2) == 0);
      ex_br_taken  = 1'($urandom_range(0, 1));
      ex_prd_taken = 1'($urandom_range(0, 1));
      ex_target    = $urandom;
      ex_pc        = $urandom;
      prd_base     = $urandom;
      prd_ofs      = $urandom;
      if_ready     = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 0;
    clear_inputs();
    @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
